reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised register file for the RV32IM pipeline, with N read ports and two write ports.
- Write port 0 is the in-order writeback stage; write port 1 is the long-latency MUL/DIV unit.
- An integrated scoreboard holds per-register busy bits for destinations of in-flight long-latency operations; it reports read hazards and issue stalls to the decode stage.
- Same-cycle writes are bypassed to read ports, so decode sees writeback data without a half-cycle write.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2: number of read ports (1..4).
- ZERO_REG, 1: when 1, register 0 is hardwired to zero, never written, never busy.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- RD_ADDR  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- RD_DATA  out  NUM_READ*DATA_WIDTH  packed read data, combinational.
- RD_BUSY  out  NUM_READ  per-port hazard: addressed register busy and not resolved this cycle.
- WR0_EN  in  1  writeback write enable.
- WR0_ADDR  in  ADDR_WIDTH  writeback destination.
- WR0_DATA  in  DATA_WIDTH  writeback data.
- WR1_EN  in  1  long-latency result write enable; also clears busy.
- WR1_ADDR  in  ADDR_WIDTH  long-latency destination.
- WR1_DATA  in  DATA_WIDTH  long-latency result.
- ISSUE_EN  in  1  request to mark ISSUE_ADDR busy (long-latency op dispatched).
- ISSUE_ADDR  in  ADDR_WIDTH  destination of the dispatched op.
- ISSUE_STALL  out  1  issue refused this cycle.
- BUSY_CNT  out  ADDR_WIDTH+1  number of registers currently busy, registered.

Behaviour:
- Single clock CLK; reset is synchronous, active-low (RESET_N sampled on the CLK rising edge).
- Reset (RESET_N=0 at a rising edge):
  - all registers 0, all busy bits 0, BUSY_CNT 0;
  - writes and issues presented in that cycle are discarded.
- While RESET_N=0, outputs are forced combinationally: RD_DATA=0, RD_BUSY=0, ISSUE_STALL=0.
- Writes: at the rising edge, WR0 and WR1 each update the array when enabled; array contents are visible one cycle later.
- Write collision: WR0 and WR1 to the same address in the same cycle → WR0 data is stored (younger instruction). The busy bit is still cleared by WR1.
- Read: RD_DATA[k] is combinational, with bypass priority WR0 (enabled, same address) > WR1 (enabled, same address) > array.
- ZERO_REG=1, register 0 addressed:
  - reads return 0 with RD_BUSY=0;
  - writes are ignored;
  - ISSUE_EN is ignored with ISSUE_STALL=0;
  - the busy bit is never set.
- RD_BUSY[k] = busy[RD_ADDR k] AND NOT (WR1_EN AND WR1_ADDR == RD_ADDR k).
- ISSUE_STALL = ISSUE_EN AND busy[ISSUE_ADDR] AND NOT (WR1_EN AND WR1_ADDR == ISSUE_ADDR). This is a WAW guard: only one outstanding write per register.
- Busy update at the rising edge: clear from WR1 is applied first, then set from an accepted issue. Issue and WR1 to the same address in the same cycle → bit ends at 1.
- WR1 to a non-busy register: data is written, busy is unchanged, no error.
- BUSY_CNT next value = BUSY_CNT + set − clear, where:
  - set = issue accepted and bit was 0 after clear;
  - clear = bit was 1 and WR1 hits it.
  - Range is 0..2**ADDR_WIDTH; it cannot wrap by construction.
- WR0 to a busy register is allowed: data is written, busy is unchanged. The decode stall logic prevents this.
- No internal state machine beyond the busy vector and counter; all outputs except BUSY_CNT are combinational from inputs and state.

Decomposition:
- Package reg_file_pkg holds:
  - defaults DATA_WIDTH=32, ADDR_WIDTH=5;
  - localparam for depth;
  - function for packed-port slicing.
- Sub-module reg_scoreboard owns:
  - the busy vector, BUSY_CNT, and the issue/clear arbitration;
  - outputs busy lookups for NUM_READ+1 addresses.
- reg_file_sb owns the data array, the write arbitration and the bypass muxes.

Test Plan:
- Reset: load x5=0xDEADBEEF, assert RESET_N=0 for one edge → read x5 returns 0x00000000, BUSY_CNT=0. While RESET_N low, RD_DATA=0.
- Bypass: WR0 x7=0x12345678 with RD_ADDR port0=x7 in the same cycle → RD_DATA port0=0x12345678 before the edge; the array holds it after the edge.
- Collision: WR0 x9=0xAAAA0000 and WR1 x9=0x5555FFFF in the same cycle → same-cycle read=0xAAAA0000, next-cycle read=0xAAAA0000, busy[x9] cleared.
- Scoreboard:
  - ISSUE x10 → RD_BUSY=1 on reads of x10, BUSY_CNT=1;
  - a second ISSUE x10 → ISSUE_STALL=1, count stays 1;
  - WR1 x10=0x00000042 → same-cycle RD_BUSY=0, RD_DATA=0x42, BUSY_CNT=0 next cycle.
- Simultaneous issue and clear: x11 busy, ISSUE x11 with WR1 x11 in the same cycle → ISSUE_STALL=0, x11 still busy, BUSY_CNT unchanged.
- x0: WR0 x0=0xFFFFFFFF, ISSUE x0 → reads of x0 return 0, RD_BUSY=0, ISSUE_STALL=0, BUSY_CNT=0. Repeat with NUM_READ=3 to cover packed port slicing.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the RV32IM register file with scoreboard.
package reg_file_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

  // Base bit of port `port` inside a bus packing ports of `width` bits each.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations: hazard lookups, WAW issue
// guard and a registered count of outstanding registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_LOOK   = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n_i,
  input  logic                         issue_en_i,
  input  logic [ADDR_WIDTH-1:0]        issue_addr_i,
  input  logic                         clr_en_i,
  input  logic [ADDR_WIDTH-1:0]        clr_addr_i,
  input  logic [NUM_LOOK*ADDR_WIDTH-1:0] look_addr_i,
  output logic [NUM_LOOK-1:0]          look_busy_o,
  output logic                         issue_stall_o,
  output logic [ADDR_WIDTH:0]          busy_cnt_o
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             issue_pend, issue_zero, issue_ok, set_hit, clr_hit;

  // A register being retired by WR1 this cycle no longer counts as a hazard.
  for (genvar gi = 0; gi < NUM_LOOK; gi++) begin : g_look
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = look_addr_i[port_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
    assign look_busy_o[gi] = rst_n_i && busy_q[addr] &&
                             !(clr_en_i && (clr_addr_i == addr));
  end

  always_comb begin
    issue_pend    = busy_q[issue_addr_i] &&
                    !(clr_en_i && (clr_addr_i == issue_addr_i));
    issue_zero    = ZERO_REG && (issue_addr_i == '0);
    issue_stall_o = rst_n_i && issue_en_i && issue_pend && !issue_zero;
    issue_ok      = issue_en_i && !issue_pend && !issue_zero;
    clr_hit       = clr_en_i && busy_q[clr_addr_i];

    // Clear first, then set, so a same-cycle retire/reissue leaves the bit set.
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    set_hit = issue_ok && !busy_d[issue_addr_i];
    if (issue_ok) busy_d[issue_addr_i] = 1'b1;

    cnt_d = cnt_q + CW'(set_hit) - CW'(clr_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two write ports, same-cycle write bypass on every read
// port, and an integrated long-latency scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_READ*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_READ-1:0]            RD_BUSY,
  input  logic                           WR0_EN,
  input  logic [ADDR_WIDTH-1:0]          WR0_ADDR,
  input  logic [DATA_WIDTH-1:0]          WR0_DATA,
  input  logic                           WR1_EN,
  input  logic [ADDR_WIDTH-1:0]          WR1_ADDR,
  input  logic [DATA_WIDTH-1:0]          WR1_DATA,
  input  logic                           ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDR,
  output logic                           ISSUE_STALL,
  output logic [ADDR_WIDTH:0]            BUSY_CNT
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam bit ZERO_B = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr0_ok, wr1_ok;

  assign wr0_ok = WR0_EN && !(ZERO_B && (WR0_ADDR == '0));
  assign wr1_ok = WR1_EN && !(ZERO_B && (WR1_ADDR == '0));

  // WR0 is issued after WR1 in the block, so on a collision its data is kept.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr1_ok) mem_q[WR1_ADDR] <= WR1_DATA;
      if (wr0_ok) mem_q[WR0_ADDR] <= WR0_DATA;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_val;

    assign addr = RD_ADDR[port_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];

    always_comb begin
      rd_val = mem_q[addr];
      if (wr1_ok && (WR1_ADDR == addr)) rd_val = WR1_DATA;
      if (wr0_ok && (WR0_ADDR == addr)) rd_val = WR0_DATA;
      if (!RESET_N || (ZERO_B && (addr == '0))) rd_val = '0;
    end

    assign RD_DATA[port_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = rd_val;
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .NUM_LOOK   (NUM_READ),
    .ZERO_REG   (ZERO_B)
  ) u_sb (
    .clk           (CLK),
    .rst_n_i       (RESET_N),
    .issue_en_i    (ISSUE_EN),
    .issue_addr_i  (ISSUE_ADDR),
    .clr_en_i      (WR1_EN),
    .clr_addr_i    (WR1_ADDR),
    .look_addr_i   (RD_ADDR),
    .look_busy_o   (RD_BUSY),
    .issue_stall_o (ISSUE_STALL),
    .busy_cnt_o    (BUSY_CNT)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then
// random traffic checked every cycle against an array-level model.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2*AW-1:0] rd_addr_a;
  logic [2*DW-1:0] rd_data_a;
  logic [1:0]      rd_busy_a;
  logic [3*AW-1:0] rd_addr_b;
  logic [3*DW-1:0] rd_data_b;
  logic [2:0]      rd_busy_b;
  logic            wr0_en, wr1_en, issue_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, issue_addr;
  logic [DW-1:0]   wr0_data, wr1_data;
  logic            stall_a, stall_b;
  logic [AW:0]     cnt_a, cnt_b;

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .ZERO_REG(1)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a),
    .RD_BUSY(rd_busy_a), .WR0_EN(wr0_en), .WR0_ADDR(wr0_addr), .WR0_DATA(wr0_data),
    .WR1_EN(wr1_en), .WR1_ADDR(wr1_addr), .WR1_DATA(wr1_data), .ISSUE_EN(issue_en),
    .ISSUE_ADDR(issue_addr), .ISSUE_STALL(stall_a), .BUSY_CNT(cnt_a));

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(3), .ZERO_REG(1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b),
    .RD_BUSY(rd_busy_b), .WR0_EN(wr0_en), .WR0_ADDR(wr0_addr), .WR0_DATA(wr0_data),
    .WR1_EN(wr1_en), .WR1_ADDR(wr1_addr), .WR1_DATA(wr1_data), .ISSUE_EN(issue_en),
    .ISSUE_ADDR(issue_addr), .ISSUE_STALL(stall_b), .BUSY_CNT(cnt_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what each register holds and whether it awaits a WR1 result.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy[DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (wr0_en && wr0_addr == a) return wr0_data;
    if (wr1_en && wr1_addr == a) return wr1_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return rst_n && (a != 0) && m_busy[a] && !(wr1_en && wr1_addr == a);
  endfunction

  function automatic int busy_total();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(m_busy[i]);
    return s;
  endfunction

  // Per-cycle compare, then advance the model to the state after the next edge.
  always @(negedge clk) begin
    logic stall_exp;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("a_rd_data%0d", k), 64'(rd_data_a[k*DW +: DW]), 64'(exp_rd(rd_addr_a[k*AW +: AW])));
      chk($sformatf("a_rd_busy%0d", k), 64'(rd_busy_a[k]), 64'(exp_busy(rd_addr_a[k*AW +: AW])));
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b_rd_data%0d", k), 64'(rd_data_b[k*DW +: DW]), 64'(exp_rd(rd_addr_b[k*AW +: AW])));
      chk($sformatf("b_rd_busy%0d", k), 64'(rd_busy_b[k]), 64'(exp_busy(rd_addr_b[k*AW +: AW])));
    end
    stall_exp = issue_en && exp_busy(issue_addr);
    chk("a_issue_stall", 64'(stall_a), 64'(stall_exp));
    chk("b_issue_stall", 64'(stall_b), 64'(stall_exp));
    chk("a_busy_cnt", 64'(cnt_a), 64'(busy_total()));
    chk("b_busy_cnt", 64'(cnt_b), 64'(busy_total()));

    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
      if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (issue_en && !stall_exp && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  end

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0;
    wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    for (int k = 0; k < 2; k++) rd_addr_a[k*AW +: AW] = a;
    for (int k = 0; k < 3; k++) rd_addr_b[k*AW +: AW] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle();
    set_rd(5'd0);
    repeat (2) @(posedge clk);

    // Reset wipes stored data; outputs are forced to zero while reset is low.
    #1; rst_n = 1'b1; idle(); wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    next_cycle(); set_rd(5'd5); settle();
    chk("x5_loaded", 64'(rd_data_a[DW-1:0]), 64'h00000000DEADBEEF);
    next_cycle(); rst_n = 1'b0; wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h1; settle();
    chk("rd_forced_in_reset", 64'(rd_data_a[DW-1:0]), 64'h0);
    next_cycle(); rst_n = 1'b1; settle();
    chk("x5_after_reset", 64'(rd_data_a[DW-1:0]), 64'h0);
    chk("cnt_after_reset", 64'(cnt_a), 64'h0);

    // Same-cycle WR0 bypass.
    next_cycle(); set_rd(5'd7); wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h12345678; settle();
    chk("bypass_wr0", 64'(rd_data_a[DW-1:0]), 64'h12345678);
    next_cycle(); settle();
    chk("x7_stored", 64'(rd_data_a[2*DW-1:DW]), 64'h12345678);

    // WR0/WR1 collision on a busy register.
    next_cycle(); issue_en = 1; issue_addr = 5'd9;
    next_cycle(); set_rd(5'd9);
    wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'hAAAA0000;
    wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h5555FFFF; settle();
    chk("collide_same", 64'(rd_data_a[DW-1:0]), 64'hAAAA0000);
    chk("collide_busy_res", 64'(rd_busy_a[0]), 64'h0);
    next_cycle(); settle();
    chk("collide_next", 64'(rd_data_a[DW-1:0]), 64'hAAAA0000);
    chk("collide_cnt", 64'(cnt_a), 64'h0);

    // Issue, WAW stall, then retire.
    next_cycle(); issue_en = 1; issue_addr = 5'd10;
    next_cycle(); set_rd(5'd10); issue_en = 1; issue_addr = 5'd10; settle();
    chk("x10_busy", 64'(rd_busy_a[0]), 64'h1);
    chk("x10_cnt1", 64'(cnt_a), 64'h1);
    chk("x10_waw_stall", 64'(stall_a), 64'h1);
    next_cycle(); settle();
    chk("x10_cnt_held", 64'(cnt_a), 64'h1);
    next_cycle(); wr1_en = 1; wr1_addr = 5'd10; wr1_data = 32'h42; settle();
    chk("x10_busy_res", 64'(rd_busy_a[1]), 64'h0);
    chk("x10_wr1_bypass", 64'(rd_data_a[DW-1:0]), 64'h42);
    next_cycle(); settle();
    chk("x10_cnt0", 64'(cnt_a), 64'h0);

    // Simultaneous retire and reissue of the same register.
    next_cycle(); issue_en = 1; issue_addr = 5'd11;
    next_cycle(); issue_en = 1; issue_addr = 5'd11; wr1_en = 1; wr1_addr = 5'd11; settle();
    chk("x11_no_stall", 64'(stall_a), 64'h0);
    next_cycle(); set_rd(5'd11); settle();
    chk("x11_still_busy", 64'(rd_busy_b[2]), 64'h1);
    chk("x11_cnt", 64'(cnt_b), 64'h1);
    next_cycle(); wr1_en = 1; wr1_addr = 5'd11;

    // Register zero on all ports, including the third port of the wider instance.
    next_cycle(); set_rd(5'd0); wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    issue_en = 1; issue_addr = 5'd0; settle();
    chk("x0_rd_same", 64'(rd_data_b[3*DW-1:2*DW]), 64'h0);
    chk("x0_no_stall", 64'(stall_b), 64'h0);
    next_cycle(); settle();
    chk("x0_rd_next", 64'(rd_data_b[3*DW-1:2*DW]), 64'h0);
    chk("x0_not_busy", 64'(rd_busy_b[2]), 64'h0);
    chk("x0_cnt", 64'(cnt_b), 64'h0);

    // Random traffic on a narrow address range to force frequent hits.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst_n      = ($urandom_range(0, 149) != 0);
      wr0_en     = ($urandom_range(0, 1) == 1);
      wr0_addr   = AW'($urandom_range(0, 15));
      wr0_data   = $urandom;
      wr1_en     = ($urandom_range(0, 9) < 3);
      wr1_addr   = AW'($urandom_range(0, 15));
      wr1_data   = $urandom;
      issue_en   = ($urandom_range(0, 9) < 4);
      issue_addr = AW'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) rd_addr_a[k*AW +: AW] = AW'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) rd_addr_b[k*AW +: AW] = AW'($urandom_range(0, 15));
    end

    next_cycle();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
